// File: rtl/cmult_acc_pkg.sv
// Shared types and helpers for the complex accumulator.
//   state_e  : frame FSM states
//   sat_max  : largest value of an aw-bit signed accumulator
//   sat_min  : smallest value of an aw-bit signed accumulator
package cmult_acc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // +(2^(aw-1) - 1)
    function automatic longint sat_max(input int unsigned aw);
        return (longint'(1) <<< (aw - 32'd1)) - longint'(1);
    endfunction

    // -2^(aw-1)
    function automatic longint sat_min(input int unsigned aw);
        return -(longint'(1) <<< (aw - 32'd1));
    endfunction

endpackage

// File: rtl/cmult_acc_lane.sv
// One lane (real or imaginary) of the complex accumulator.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : start a new sum with the sign-extended input
//   add        : add the input into the running sum with saturation
//   din        : signed product
//   acc_nxt_c  : value the accumulator takes on this beat (combinational)
//   clamp_c    : this beat's add saturated (combinational)
module cmult_acc_lane
    import cmult_acc_pkg::*;
#(
    parameter int unsigned PWIDTH = 18,
    parameter int unsigned AW     = 26
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     add,
    input  logic signed [PWIDTH-1:0] din,
    output logic signed [AW-1:0]     acc_nxt_c,
    output logic                     clamp_c
);

    localparam logic signed [AW-1:0] ACC_MAX = AW'(sat_max(AW));
    localparam logic signed [AW-1:0] ACC_MIN = AW'(sat_min(AW));

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] din_ext;
    logic signed [AW:0]   sum;

    // Next value: load, or a one-bit-wider add clamped back into AW bits.
    always_comb begin
        din_ext   = AW'(din);
        sum       = (AW+1)'(acc_q) + (AW+1)'(din_ext);
        clamp_c   = 1'b0;
        acc_nxt_c = din_ext;
        if (add) begin
            if (sum[AW] != sum[AW-1]) begin
                clamp_c   = 1'b1;
                acc_nxt_c = sum[AW] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_nxt_c = sum[AW-1:0];
            end
        end
        acc_d = acc_q;
        if (load || add) begin
            acc_d = acc_nxt_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/cmult_acc.sv
// Complex frame accumulator behind the complex multiplier.
// Sums pr/pi products over a frame (closed by in_last or MAX_LEN samples)
// and presents the result in a valid/ready output register.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid, in_last    : product strobe and end-of-frame marker
//   in_pr, in_pi         : signed products
//   out_ready            : consumer accepts the held result
//   err_clr              : clears drop_err
//   out_valid            : result register full
//   out_re, out_im       : accumulated sums
//   out_count            : samples in the frame
//   out_sat, out_trunc   : saturation seen / frame closed by MAX_LEN
//   drop_err             : sticky, a result was discarded
module cmult_acc
    import cmult_acc_pkg::*;
#(
    parameter  int unsigned PWIDTH  = 18,
    parameter  int unsigned GUARD   = 8,
    parameter  int unsigned MAX_LEN = 64,
    localparam int unsigned AW      = PWIDTH + GUARD,
    localparam int unsigned CW      = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic signed [PWIDTH-1:0] in_pr,
    input  logic signed [PWIDTH-1:0] in_pi,
    input  logic                     out_ready,
    input  logic                     err_clr,
    output logic                     out_valid,
    output logic signed [AW-1:0]     out_re,
    output logic signed [AW-1:0]     out_im,
    output logic [CW-1:0]            out_count,
    output logic                     out_sat,
    output logic                     out_trunc,
    output logic                     drop_err
);

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
    logic          sat_q, sat_d, sat_nxt;

    logic          load, add, close, hit_max, trunc;
    logic          clamp_re, clamp_im;
    logic signed [AW-1:0] acc_re_nxt, acc_im_nxt;

    logic                 out_valid_q, out_valid_d;
    logic signed [AW-1:0] res_re_q, res_re_d;
    logic signed [AW-1:0] res_im_q, res_im_d;
    logic [CW-1:0]        res_cnt_q, res_cnt_d;
    logic                 res_sat_q, res_sat_d;
    logic                 res_trunc_q, res_trunc_d;
    logic                 drop_q, drop_d;

    cmult_acc_lane #(.PWIDTH(PWIDTH), .AW(AW)) u_lane_re (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .add       (add),
        .din       (in_pr),
        .acc_nxt_c (acc_re_nxt),
        .clamp_c   (clamp_re)
    );

    cmult_acc_lane #(.PWIDTH(PWIDTH), .AW(AW)) u_lane_im (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .add       (add),
        .din       (in_pi),
        .acc_nxt_c (acc_im_nxt),
        .clamp_c   (clamp_im)
    );

    // Frame FSM: first beat loads, later beats add; a close returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        load    = 1'b0;
        add     = 1'b0;
        cnt_nxt = CW'(1);
        sat_nxt = 1'b0;

        case (state_q)
            IDLE: begin
                load    = in_valid;
                cnt_nxt = CW'(1);
                sat_nxt = 1'b0;
            end
            RUN: begin
                add     = in_valid;
                cnt_nxt = cnt_q + CW'(1);
                sat_nxt = sat_q | clamp_re | clamp_im;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        hit_max = (cnt_nxt == CW'(MAX_LEN));
        close   = in_valid & (in_last | hit_max);
        trunc   = hit_max & ~in_last;

        if (in_valid) begin
            cnt_d   = cnt_nxt;
            sat_d   = sat_nxt;
            state_d = close ? IDLE : RUN;
        end
    end

    // Result register, handshake and drop reporting.
    always_comb begin
        out_valid_d = out_valid_q;
        res_re_d    = res_re_q;
        res_im_d    = res_im_q;
        res_cnt_d   = res_cnt_q;
        res_sat_d   = res_sat_q;
        res_trunc_d = res_trunc_q;
        drop_d      = drop_q;

        if (close && (!out_valid_q || out_ready)) begin
            out_valid_d = 1'b1;
            res_re_d    = acc_re_nxt;
            res_im_d    = acc_im_nxt;
            res_cnt_d   = cnt_nxt;
            res_sat_d   = sat_nxt;
            res_trunc_d = trunc;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A new drop beats a simultaneous clear.
        if (close && out_valid_q && !out_ready) begin
            drop_d = 1'b1;
        end else if (err_clr) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            res_re_q    <= '0;
            res_im_q    <= '0;
            res_cnt_q   <= '0;
            res_sat_q   <= 1'b0;
            res_trunc_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            res_re_q    <= res_re_d;
            res_im_q    <= res_im_d;
            res_cnt_q   <= res_cnt_d;
            res_sat_q   <= res_sat_d;
            res_trunc_q <= res_trunc_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = res_re_q;
    assign out_im    = res_im_q;
    assign out_count = res_cnt_q;
    assign out_sat   = res_sat_q;
    assign out_trunc = res_trunc_q;
    assign drop_err  = drop_q;

endmodule

// File: doc/cmult_acc.md
Name: cmult_acc

Overview:
Complex accumulator placed directly downstream of the complex multiplier. It consumes the multiplier's pr/pi product stream, plus a valid/last marker that the integrator delays by the multiplier's 6-cycle latency. It sums products over a frame to form a complex dot product or correlation, then presents the result on a valid/ready output with saturation, truncation and drop reporting.

Parameters:
PWIDTH, 18, product width; matches the multiplier's AWIDTH+BWIDTH+1 at defaults 8/9.
GUARD, 8, guard bits; accumulator width AW = PWIDTH+GUARD.
MAX_LEN, 64, maximum samples per frame before a forced close.
CW, $clog2(MAX_LEN+1), derived; width of the sample count.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  in_pr/in_pi hold a product this cycle.
in_last  in  1  final product of the frame; qualified by in_valid.
in_pr  in  PWIDTH  signed real product.
in_pi  in  PWIDTH  signed imaginary product.
out_ready  in  1  consumer accepts the result.
err_clr  in  1  synchronous clear of drop_err.
out_valid  out  1  result register is full.
out_re  out  AW  signed accumulated real part.
out_im  out  AW  signed accumulated imaginary part.
out_count  out  CW  number of samples in the frame.
out_sat  out  1  at least one saturation occurred in the frame.
out_trunc  out  1  frame was closed by MAX_LEN, not by in_last.
drop_err  out  1  sticky flag: a frame result was discarded.

Behaviour:
- Reset is asynchronous and active-low. Clock is clk, reset is rst_n; both are fixed.
- Reset values: every output is 0, the accumulators are 0, the FSM is in IDLE. Reset mid-frame discards the partial sums entirely.
- Input has no back-pressure. Every in_valid beat is consumed. Gaps (in_valid=0) are allowed and leave all state unchanged. in_last is ignored when in_valid=0.
- FSM IDLE: on in_valid, load acc = sign-extended input, cnt = 1, sat flag = 0, and go to RUN. If that beat is also a close event, the frame closes immediately and the FSM stays in IDLE.
- FSM RUN: on in_valid, acc = sat(acc + sext(in)) per lane, cnt += 1.
  - The frame sat flag ORs in any clamp from either lane.
  - A close event returns the FSM to IDLE.
- Close event: in_valid together with in_last, or in_valid where this beat makes cnt = MAX_LEN. out_trunc = 1 only for the MAX_LEN case without in_last. A beat that has in_last and also hits MAX_LEN gives out_trunc = 0.
- Saturation: compute the sum at AW+1 bits. Clamp to +(2^(AW-1)-1) or -2^(AW-1) on overflow. Each lane clamps independently.
- Result register: on a close at edge t, out_valid = 1 after edge t, so latency is 1 cycle from the closing beat. It loads out_re, out_im, out_count, out_sat and out_trunc together, and holds them stable until out_valid & out_ready.
- Handshake: out_valid & out_ready clears out_valid at the next edge, unless a close occurs in the same cycle. In that case the new result loads and out_valid stays 1 (back-to-back, no bubble).
- Drop: if a close occurs while out_valid = 1 and out_ready = 0, the new result is discarded, the held result is untouched, and drop_err is set.
- drop_err stays set until err_clr or reset. When err_clr coincides with a new drop, the set wins.
- out_valid must not depend combinationally on out_ready.

Decomposition:
- Package cmult_acc_pkg holds:
  - the FSM state enum {IDLE, RUN};
  - the functions for the saturation limit constants, parameterised on AW.
- One sub-module, cmult_acc_lane: a per-lane signed accumulator with load/add/saturate and a clamp flag. It is instantiated twice (re, im).

Test Plan:
1. Frame (100,-5), (200,7), (-50,0) with last on the third beat, out_ready=1 -> one cycle later out_valid=1, re=250, im=2, count=3, sat=0, trunc=0.
2. Single beat (-131072,131071) with in_last -> re=-131072, im=131071, count=1, FSM back to IDLE. Idle gaps inside a frame leave the sums unchanged.
3. GUARD=1 (AW=19): three beats of (131071,-131072) -> re=262143, im=-262144, sat=1.
4. 64 beats of (1,-1) with no last -> re=64, im=-64, count=64, trunc=1. Beat 65 with last -> new frame, re=1, count=1, trunc=0.
5. out_ready=0 while two frames close -> the first result is held unchanged and drop_err=1. Pulse err_clr -> drop_err=0. Then out_ready=1 -> the first result is delivered once.
6. Close coincides with the accepting handshake -> out_valid stays 1 with new data. Assert rst_n low mid-frame -> all outputs 0, and the next frame's result excludes the pre-reset beats.
